// File: rtl/embox_mc.sv
// embox_mc: multi-channel 64-bit mailbox behind a 32-bit memory interface.
// Each channel is an independent FIFO with fill count, sticky overflow flag
// and a programmable interrupt threshold.
module embox_mc #(
  parameter int DW   = 32,
  parameter int RFAW = 5,
  parameter int FAW  = 4,
  parameter int NCH  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mi_en,
  input  logic            mi_we,
  input  logic [19:0]     mi_addr,
  input  logic [DW-1:0]   mi_din,
  output logic [DW-1:0]   mi_dout,
  output logic [NCH-1:0]  embox_not_empty,
  output logic [NCH-1:0]  embox_full,
  output logic [NCH-1:0]  embox_irq
);

  localparam int CW    = RFAW - 2;
  localparam int DEPTH = 1 << FAW;

  logic [CW-1:0]   chan;
  logic [1:0]      regsel;
  logic            unused_addr_bits;
  logic [DW-1:0]   rdata;

  logic [2*DW-1:0] head    [NCH];
  logic [FAW:0]    cnt_v   [NCH];
  logic [FAW:0]    thr_v   [NCH];
  logic [NCH-1:0]  ovf_v;
  logic [NCH-1:0]  ien_v;

  assign chan             = mi_addr[RFAW+1:4];
  assign regsel           = mi_addr[3:2];
  assign unused_addr_bits = ^{mi_addr[19:RFAW+2], mi_addr[1:0]};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [2*DW-1:0] mem [DEPTH];
    logic [FAW-1:0]  wr_ptr, rd_ptr;
    logic [FAW:0]    cnt, cnt_next, thr, thr_next, thr_eff;
    logic [DW-1:0]   shadow;
    logic            ovf, ien, ien_next, irq_q;
    logic            sel, is_full, is_empty;
    logic            push, push_ok, pop_ok, cfg_wr, stat_wr, lo_wr;

    assign sel      = mi_en && (32'(chan) == c);
    assign is_full  = (cnt == (FAW+1)'(DEPTH));
    assign is_empty = (cnt == '0);
    assign lo_wr    = sel && mi_we && (regsel == 2'd0);
    assign push     = sel && mi_we && (regsel == 2'd1);
    assign stat_wr  = sel && mi_we && (regsel == 2'd2);
    assign cfg_wr   = sel && mi_we && (regsel == 2'd3);
    assign push_ok  = push && !is_full;
    assign pop_ok   = sel && !mi_we && (regsel == 2'd1) && !is_empty;

    // Next count and config so the interrupt tracks the same edge as the count
    always_comb begin
      cnt_next = cnt;
      if (push_ok)
        cnt_next = cnt + 1'b1;
      else if (pop_ok)
        cnt_next = cnt - 1'b1;
      thr_next = cfg_wr ? mi_din[FAW:0] : thr;
      ien_next = cfg_wr ? mi_din[16] : ien;
      thr_eff  = (thr_next == '0) ? (FAW+1)'(1) : thr_next;
    end

    // FIFO storage, written only on an accepted push
    always_ff @(posedge clk) begin
      if (push_ok)
        mem[wr_ptr] <= {mi_din, shadow};
    end

    // Channel control state: pointers, count, flags, config, shadow, interrupt
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
        thr    <= '0;
        ien    <= 1'b0;
        shadow <= '0;
        irq_q  <= 1'b0;
      end else begin
        if (lo_wr)
          shadow <= mi_din;
        if (push_ok)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)
          rd_ptr <= rd_ptr + 1'b1;
        if (push && is_full)
          ovf <= 1'b1;
        else if (stat_wr && mi_din[2])
          ovf <= 1'b0;
        cnt   <= cnt_next;
        thr   <= thr_next;
        ien   <= ien_next;
        irq_q <= ien_next && (cnt_next >= thr_eff);
      end
    end

    assign head[c]            = mem[rd_ptr];
    assign cnt_v[c]           = cnt;
    assign thr_v[c]           = thr;
    assign ovf_v[c]           = ovf;
    assign ien_v[c]           = ien;
    assign embox_not_empty[c] = !is_empty;
    assign embox_full[c]      = is_full;
    assign embox_irq[c]       = irq_q;
  end

  // Read mux; unmapped channels and empty FIFOs read as zero
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (32'(chan) == i) begin
        case (regsel)
          2'd0: rdata = embox_not_empty[i] ? head[i][DW-1:0] : '0;
          2'd1: rdata = embox_not_empty[i] ? head[i][2*DW-1:DW] : '0;
          2'd2: begin
            rdata[0]       = embox_not_empty[i];
            rdata[1]       = embox_full[i];
            rdata[2]       = ovf_v[i];
            rdata[8+FAW:8] = cnt_v[i];
          end
          default: begin
            rdata[FAW:0] = thr_v[i];
            rdata[16]    = ien_v[i];
          end
        endcase
      end
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mi_dout <= '0;
    else if (mi_en && !mi_we)
      mi_dout <= rdata;
  end

endmodule

// File: tb/tb_embox_mc.sv
// tb_embox_mc: randomized and directed bench for embox_mc against a
// queue-based mailbox model.
module tb_embox_mc;

  localparam int NCH   = 2;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            mi_en = 1'b0;
  logic            mi_we = 1'b0;
  logic [19:0]     mi_addr = '0;
  logic [31:0]     mi_din = '0;
  logic [31:0]     mi_dout;
  logic [NCH-1:0]  embox_not_empty, embox_full, embox_irq;

  int checks = 0;
  int errors = 0;

  // Mailbox model
  logic [63:0] mq [NCH][$];
  logic [31:0] shadow_m [NCH];
  logic        ovf_m    [NCH];
  logic [4:0]  thr_m    [NCH];
  logic        ien_m    [NCH];

  embox_mc #(.DW(32), .RFAW(5), .FAW(4), .NCH(NCH)) dut (
    .clk(clk), .reset(reset), .mi_en(mi_en), .mi_we(mi_we),
    .mi_addr(mi_addr), .mi_din(mi_din), .mi_dout(mi_dout),
    .embox_not_empty(embox_not_empty), .embox_full(embox_full),
    .embox_irq(embox_irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      shadow_m[c] = '0;
      ovf_m[c]    = 1'b0;
      thr_m[c]    = '0;
      ien_m[c]    = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_stat(input int c);
    logic [31:0] s;
    s       = '0;
    s[0]    = (mq[c].size() != 0);
    s[1]    = (mq[c].size() == DEPTH);
    s[2]    = ovf_m[c];
    s[12:8] = 5'(mq[c].size());
    return s;
  endfunction

  function automatic logic model_irq(input int c);
    int t;
    t = (thr_m[c] == 0) ? 1 : int'(thr_m[c]);
    return ien_m[c] && (mq[c].size() >= t);
  endfunction

  task automatic check_flags();
    logic [NCH-1:0] ne, fu, iq;
    for (int c = 0; c < NCH; c++) begin
      ne[c] = (mq[c].size() != 0);
      fu[c] = (mq[c].size() == DEPTH);
      iq[c] = model_irq(c);
    end
    checkOutput("not_empty", 32'(embox_not_empty), 32'(ne));
    checkOutput("full", 32'(embox_full), 32'(fu));
    checkOutput("irq", 32'(embox_irq), 32'(iq));
  endtask

  // One bus access; the model is updated alongside and read data is checked
  task automatic applyStimulus(input int c, input int r, input logic we, input logic [31:0] data);
    logic [31:0] exp;
    exp = '0;
    if (!we && c < NCH) begin
      case (r)
        0: exp = (mq[c].size() != 0) ? mq[c][0][31:0] : '0;
        1: exp = (mq[c].size() != 0) ? mq[c][0][63:32] : '0;
        2: exp = model_stat(c);
        default: begin exp[4:0] = thr_m[c]; exp[16] = ien_m[c]; end
      endcase
    end
    @(negedge clk);
    mi_en   = 1'b1;
    mi_we   = we;
    mi_addr = 20'(c * 16 + r * 4);
    mi_din  = data;
    @(posedge clk);
    #1;
    mi_en = 1'b0;
    mi_we = 1'b0;
    if (c < NCH) begin
      if (we) begin
        case (r)
          0: shadow_m[c] = data;
          1: if (mq[c].size() == DEPTH) ovf_m[c] = 1'b1;
             else mq[c].push_back({data, shadow_m[c]});
          2: if (data[2]) ovf_m[c] = 1'b0;
          default: begin thr_m[c] = data[4:0]; ien_m[c] = data[16]; end
        endcase
      end else if (r == 1 && mq[c].size() != 0) begin
        void'(mq[c].pop_front());
      end
    end
    if (!we)
      checkOutput($sformatf("rd_c%0d_r%0d", c, r), mi_dout, exp);
    check_flags();
  endtask

  task automatic push(input int c, input logic [31:0] lo, input logic [31:0] hi);
    applyStimulus(c, 0, 1'b1, lo);
    applyStimulus(c, 1, 1'b1, hi);
  endtask

  task automatic pop(input int c);
    applyStimulus(c, 0, 1'b0, 32'h0);
    applyStimulus(c, 1, 1'b0, 32'h0);
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dout", mi_dout, 32'h0);
    check_flags();
    @(negedge clk);
    reset = 1'b0;

    // Basic push and read back
    push(0, 32'h11111111, 32'h22222222);
    checkOutput("t1_ne0", 32'(embox_not_empty[0]), 32'h1);
    applyStimulus(0, 0, 1'b0, 0);
    checkOutput("t1_lo", mi_dout, 32'h11111111);
    applyStimulus(0, 1, 1'b0, 0);
    checkOutput("t1_hi", mi_dout, 32'h22222222);
    applyStimulus(0, 2, 1'b0, 0);
    checkOutput("t1_stat", mi_dout, 32'h0);

    // Fill ch1, overflow, drain in order, clear overflow
    for (int i = 0; i < 17; i++)
      applyStimulus(1, 1, 1'b1, 32'(i));
    checkOutput("t2_full1", 32'(embox_full[1]), 32'h1);
    applyStimulus(1, 2, 1'b0, 0);
    checkOutput("t2_stat", mi_dout, 32'h1007);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 1, 1'b0, 0);
      checkOutput("t2_drain", mi_dout, 32'(i));
    end
    applyStimulus(1, 2, 1'b1, 32'h4);
    applyStimulus(1, 2, 1'b0, 0);
    checkOutput("t2_ovf_clr", mi_dout, 32'h0);

    // Pointer wrap with low occupancy
    for (int i = 0; i < 40; i++) begin
      push(0, $urandom, $urandom);
      if (mq[0].size() >= 3 || ($urandom_range(0, 1) == 1))
        pop(0);
    end
    while (mq[0].size() != 0)
      pop(0);

    // Interrupt threshold on ch0
    applyStimulus(0, 3, 1'b1, 32'h10003);
    push(0, 32'hA, 32'hB);
    push(0, 32'hC, 32'hD);
    checkOutput("t4_irq_low", 32'(embox_irq[0]), 32'h0);
    push(0, 32'hE, 32'hF);
    checkOutput("t4_irq_high", 32'(embox_irq[0]), 32'h1);
    push(1, 32'h5, 32'h6);
    pop(1);
    checkOutput("t4_irq_ch1", 32'(embox_irq[0]), 32'h1);
    pop(0);
    checkOutput("t4_irq_drop", 32'(embox_irq[0]), 32'h0);
    while (mq[0].size() != 0)
      pop(0);
    applyStimulus(0, 3, 1'b1, 32'h0);

    // Empty pop and unmapped channel
    applyStimulus(1, 1, 1'b0, 0);
    checkOutput("t5_empty_hi", mi_dout, 32'h0);
    applyStimulus(1, 2, 1'b0, 0);
    checkOutput("t5_empty_stat", mi_dout, 32'h0);
    for (int r = 0; r < 4; r++)
      applyStimulus(NCH, r, 1'b1, 32'hFFFFFFFF);
    for (int r = 0; r < 4; r++)
      applyStimulus(NCH, r, 1'b0, 0);

    // Randomized mixed traffic, including unmapped channels
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), $urandom);

    // Asynchronous reset with ch0 holding entries
    for (int c = 0; c < NCH; c++) begin
      applyStimulus(c, 3, 1'b1, 32'h10001);
      while (mq[c].size() != 0) pop(c);
    end
    for (int i = 0; i < 5; i++)
      push(0, 32'h100 + 32'(i), 32'h200 + 32'(i));
    applyStimulus(0, 0, 1'b0, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("t6_ne", 32'(embox_not_empty), 32'h0);
    checkOutput("t6_full", 32'(embox_full), 32'h0);
    checkOutput("t6_irq", 32'(embox_irq), 32'h0);
    checkOutput("t6_dout", mi_dout, 32'h0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 2, 1'b0, 0);
    checkOutput("t6_stat", mi_dout, 32'h0);
    applyStimulus(0, 3, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
